// File: rtl/aesl_deadlock_stall_detector.sv
// Purpose: detects mutually stalled processes and walks each dependence cycle for the deadlock report unit.
// Latency: ANNOUNCE STALL_THRESH+1 cycles after blocking begins; first hop 1 cycle after origin_in.
// Backpressure: none on the inputs; a closed walk holds in CLOSE until token_clear. Optional trace: AESL_DL_STALL_TRACE_EN.
module aesl_deadlock_stall_detector #(
    parameter int PROC_NUM     = 2,
    parameter int STALL_THRESH = 16,
    parameter int CNT_W        = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PROC_NUM-1:0]          proc_blocked,
    input  logic [PROC_NUM*PROC_NUM-1:0] proc_dep,
    input  logic [PROC_NUM-1:0]          origin_in,
    input  logic                         token_clear,
    output logic [PROC_NUM-1:0]          dl_in_vec,
    output logic                         dl_locked,
    output logic                         walk_trunc
);

    typedef enum logic [2:0] {MONITOR, ANNOUNCE, WAIT_ORIGIN, WALK, CLOSE} state_t;

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);
    localparam int               HOP_W  = $clog2(PROC_NUM + 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt [PROC_NUM];
    logic [PROC_NUM-1:0] stalled, det_reg, cur, visited, org;
    logic [PROC_NUM-1:0] cur_row, nxt_raw, nxt, walk_emit, origin_low;
    logic                closure, walk_force, walk_close;
    logic [HOP_W-1:0]    hops;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PROC_NUM; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < PROC_NUM; i++) begin
                if (!proc_blocked[i])
                    cnt[i] <= '0;
                else if (cnt[i] != THRESH)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // A stalled set closes when every member waits on something, and only on other stalled members.
    always_comb begin
        stalled = '0;
        cur_row = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            stalled[i] = (cnt[i] == THRESH);
            if (cur[i]) cur_row = cur_row | proc_dep[i*PROC_NUM +: PROC_NUM];
        end
        closure = (stalled != '0);
        for (int i = 0; i < PROC_NUM; i++) begin
            if (stalled[i] && ((proc_dep[i*PROC_NUM +: PROC_NUM] == '0) ||
                               ((proc_dep[i*PROC_NUM +: PROC_NUM] & ~stalled) != '0)))
                closure = 1'b0;
        end
    end

    assign origin_low = origin_in & (~origin_in + PROC_NUM'(1));
    assign nxt_raw    = cur_row & det_reg;
    assign nxt        = nxt_raw & (~nxt_raw + PROC_NUM'(1));
    assign walk_force = (nxt != org) &&
                        ((nxt == '0) || ((nxt & visited) != '0) || (hops >= HOP_W'(PROC_NUM)));
    assign walk_close = walk_force || (nxt == org);
    assign walk_emit  = walk_force ? org : nxt;

    always_comb begin
        case (state)
            ANNOUNCE: dl_in_vec = det_reg;
            WALK:     dl_in_vec = walk_emit;
            default:  dl_in_vec = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= MONITOR;
            det_reg    <= '0;
            cur        <= '0;
            visited    <= '0;
            org        <= '0;
            hops       <= '0;
            dl_locked  <= 1'b0;
            walk_trunc <= 1'b0;
        end else begin
            case (state)
                MONITOR: begin
                    if (closure) begin
                        det_reg   <= stalled;
                        dl_locked <= 1'b1;
                        state     <= ANNOUNCE;
                    end
                end
                ANNOUNCE: state <= WAIT_ORIGIN;
                WAIT_ORIGIN: begin
                    if (origin_in != '0) begin
                        cur     <= origin_low;
                        visited <= origin_low;
                        org     <= origin_low;
                        hops    <= '0;
                        state   <= WALK;
                    end
                end
                WALK: begin
                    if (walk_close) begin
                        if (walk_force) walk_trunc <= 1'b1;
                        state <= token_clear ? WAIT_ORIGIN : CLOSE;
                    end else begin
                        cur     <= nxt;
                        visited <= visited | nxt;
                        hops    <= hops + 1'b1;
                    end
                end
                CLOSE: begin
                    if (token_clear) state <= WAIT_ORIGIN;
                end
                default: state <= MONITOR;
            endcase
        end
    end

`ifdef AESL_DL_STALL_TRACE_EN
    logic [31:0] cyc;

    function automatic int onehot_idx(input logic [PROC_NUM-1:0] v);
        for (int i = 0; i < PROC_NUM; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (state == ANNOUNCE)
                $display("DL ANNOUNCE cyc=%0d vec=%h", cyc, det_reg);
            if (state == WALK) begin
                $display("DL HOP cyc=%0d from=%0d to=%0d", cyc, onehot_idx(cur), onehot_idx(walk_emit));
                if (walk_force) $display("DL TRUNC");
            end
        end
    end
`endif

endmodule

// File: tb/tb_aesl_deadlock_stall_detector.sv
// Bench for aesl_deadlock_stall_detector with PROC_NUM=2, STALL_THRESH=4.
// Each step drives inputs on the falling edge and queues the outputs expected after the next rising edge.
module tb_aesl_deadlock_stall_detector;

    logic       clock;
    logic       reset;
    logic [1:0] proc_blocked;
    logic [3:0] proc_dep;
    logic [1:0] origin_in;
    logic       token_clear;
    logic [1:0] dl_in_vec;
    logic       dl_locked;
    logic       walk_trunc;

    typedef struct {
        string      tag;
        logic [3:0] v;      // {dl_in_vec, dl_locked, walk_trunc}
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    aesl_deadlock_stall_detector #(
        .PROC_NUM    (2),
        .STALL_THRESH(4),
        .CNT_W       (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .proc_blocked(proc_blocked),
        .proc_dep    (proc_dep),
        .origin_in   (origin_in),
        .token_clear (token_clear),
        .dl_in_vec   (dl_in_vec),
        .dl_locked   (dl_locked),
        .walk_trunc  (walk_trunc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b (vec,locked,trunc) expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] blk, input logic [3:0] dep,
                        input logic [1:0] org, input logic tc,
                        input logic [1:0] ev, input logic el, input logic et, input string tag);
        exp_t e;
        @(negedge clock);
        reset        = rst;
        proc_blocked = blk;
        proc_dep     = dep;
        origin_in    = org;
        token_clear  = tc;
        e.tag = tag;
        e.v   = {ev, el, et};
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq(e.tag, {dl_in_vec, dl_locked, walk_trunc}, e.v);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; proc_blocked = '0; proc_dep = '0; origin_in = '0; token_clear = 1'b0;

        step(1, 2'b00, 4'b0000, 2'b00, 0, 2'b00, 0, 0, "reset0");
        step(1, 2'b00, 4'b0000, 2'b00, 0, 2'b00, 0, 0, "reset1");

        // proc0 waits on an unstalled proc1: never a closed set
        for (int i = 0; i < 10; i++)
            step(0, 2'b01, 4'b0010, 2'b00, 0, 2'b00, 0, 0, "no_dl");

        // Mutual wait
        step(1, 2'b00, 4'b0000, 2'b00, 0, 2'b00, 0, 0, "rst_a");
        for (int i = 0; i < 4; i++)
            step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b00, 0, 0, "mw_fill");
        step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b11, 1, 0, "mw_announce");
        step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b00, 1, 0, "mw_wait");
        step(0, 2'b11, 4'b0110, 2'b01, 0, 2'b10, 1, 0, "mw_hop1");
        step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b01, 1, 0, "mw_close");
        step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b00, 1, 0, "mw_closed");
        step(0, 2'b11, 4'b0110, 2'b00, 1, 2'b00, 1, 0, "mw_clear");
        step(0, 2'b11, 4'b0110, 2'b10, 0, 2'b01, 1, 0, "mw2_hop1");
        step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b10, 1, 0, "mw2_close");
        // token_clear coincides with the closing emit
        step(0, 2'b11, 4'b0110, 2'b00, 1, 2'b00, 1, 0, "mw2_clr_same");
        step(0, 2'b11, 4'b0110, 2'b01, 0, 2'b10, 1, 0, "mw3_hop1");
        step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b01, 1, 0, "mw3_close");
        step(0, 2'b11, 4'b0110, 2'b00, 1, 2'b00, 1, 0, "mw3_clr");

        // Deadlock stays latched after the processes unblock
        for (int i = 0; i < 3; i++)
            step(0, 2'b00, 4'b0110, 2'b00, 0, 2'b00, 1, 0, "sticky_idle");
        step(0, 2'b00, 4'b0110, 2'b01, 0, 2'b10, 1, 0, "sticky_hop");
        step(0, 2'b00, 4'b0110, 2'b00, 0, 2'b01, 1, 0, "sticky_close");
        step(0, 2'b00, 4'b0110, 2'b00, 1, 2'b00, 1, 0, "sticky_clr");

        // Transient unblock restarts the stall count
        step(1, 2'b00, 4'b0110, 2'b00, 0, 2'b00, 0, 0, "rst_b");
        for (int i = 0; i < 3; i++)
            step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b00, 0, 0, "tr_blk");
        step(0, 2'b10, 4'b0110, 2'b00, 0, 2'b00, 0, 0, "tr_unblk");
        for (int i = 0; i < 4; i++)
            step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b00, 0, 0, "tr_reblk");
        step(0, 2'b11, 4'b0110, 2'b00, 0, 2'b11, 1, 0, "tr_announce");

        // proc1 waits only on itself: walk from proc0 is force-closed
        step(1, 2'b00, 4'b1010, 2'b00, 0, 2'b00, 0, 0, "rst_c");
        for (int i = 0; i < 4; i++)
            step(0, 2'b11, 4'b1010, 2'b00, 0, 2'b00, 0, 0, "sl_fill");
        step(0, 2'b11, 4'b1010, 2'b00, 0, 2'b11, 1, 0, "sl_announce");
        step(0, 2'b11, 4'b1010, 2'b00, 0, 2'b00, 1, 0, "sl_wait");
        step(0, 2'b11, 4'b1010, 2'b01, 0, 2'b10, 1, 0, "sl_hop1");
        step(0, 2'b11, 4'b1010, 2'b00, 0, 2'b01, 1, 0, "sl_force");
        step(0, 2'b11, 4'b1010, 2'b00, 0, 2'b00, 1, 1, "sl_trunc");
        step(0, 2'b11, 4'b1010, 2'b00, 1, 2'b00, 1, 1, "sl_clr");
        // non-one-hot origin resolves to its lowest bit
        step(0, 2'b11, 4'b1010, 2'b11, 0, 2'b10, 1, 1, "sl_lowbit");

        // Reset while walking
        step(1, 2'b11, 4'b1010, 2'b00, 0, 2'b00, 0, 0, "rst_midwalk");
        for (int i = 0; i < 4; i++)
            step(0, 2'b11, 4'b1010, 2'b00, 0, 2'b00, 0, 0, "post_rst_fill");
        step(0, 2'b11, 4'b1010, 2'b00, 0, 2'b11, 1, 0, "post_rst_announce");

        @(posedge clock);
        #2;
        check_eq("sb_drain", 4'(sb.size()), 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
